cordic_vectoring: RTL
=====================

// Module: cordic_vectoring
// PURPOSE
//  Iterative vectoring-mode CORDIC, the inverse of the rotation-mode sine generator.
//  Takes a signed 8-bit (X,Y) sample pair and returns its phase (16-bit binary angle) and gain-compensated magnitude.
//  Sits on the receive/analysis side of the sine path to recover phase and amplitude of generated samples.
//  Performs one micro-rotation per clock; the start/busy/done handshake serialises requests.
// PARAMETERS
//  XY_SZ  8   width of signed x_in/y_in
//  STG    8   micro-rotation count; legal range 1..14
// PORTS
//  CLK_100MHZ  in   1        sole clock, all logic on posedge
//  RST_N       in   1        synchronous, active-low reset
//  start       in   1        request; sampled only in IDLE
//  x_in        in   XY_SZ    signed X component
//  y_in        in   XY_SZ    signed Y component
//  busy        out  1        high in ITER and DONE
//  done        out  1        one-cycle pulse when results valid
//  angle_out   out  16       phase, 0x0000=0, 0x4000=+pi/2, 0x8000=pi, 0xC000=-pi/2
//  mag_out     out  XY_SZ+1  unsigned magnitude, gain-compensated
// BEHAVIOUR
//  Reset (RST_N=0 at an edge): state=IDLE, iteration counter=0, busy=0, done=0,
//   angle_out=0, mag_out=0.
//  - Reset wins over every other input, including mid-ITER; the partial result is discarded.
//  States: IDLE -> ITER -> DONE -> IDLE.
//  - IDLE & start: capture and pre-rotate, counter i=0, go to ITER.
//  - IDLE & !start: hold.
//  - ITER: apply micro-rotation i, then i++.
//    - When i==STG-1: register angle_out/mag_out, set done=1, go to DONE.
//  - DONE: done=0, go to IDLE. start is ignored in ITER and DONE.
//  Latency: start sampled at edge k -> done=1 after edge k+STG, for exactly one cycle.
//   Minimum request spacing is STG+2 cycles.
//  Outputs hold their last values until the next completion or reset.
//  Internal x/y width is XY_SZ+2 signed, which covers sqrt2*128*1.647 with no overflow.
//  z is 16-bit signed and wraps modulo 2^16; the wrap is intentional.
//  Pre-rotation (x0,y0,z0 from x_in,y_in, both sign-extended):
//  - x_in>=0:           (x,y,z) = (x_in, y_in, 0x0000)
//  - x_in<0, y_in>=0:   (x,y,z) = (y_in, -x_in, 0x4000)
//  - x_in<0, y_in<0:    (x,y,z) = (-y_in, x_in, 0xC000)
//  Micro-rotation i (arithmetic >>>, atan from table):
//  - y>=0: x+= y>>>i; y-= x>>>i; z+= atan[i]
//  - y<0:  x-= y>>>i; y+= x>>>i; z-= atan[i]
//  - All three updates use the old x, y and z.
//  Outputs:
//  - angle_out = z_final.
//  - mag_out = (x_final * 155) >> 8, i.e. 1/1.647 compensation, truncated.
//    Clamp to 0 if negative, saturate at 2^(XY_SZ+1)-1.
//  - Input (0,0) yields angle_out=0x0000, mag_out=0.
//  - Input (-128,-128) must produce neither overflow nor a wrong quadrant.
// STRUCTURE
//  cordic_pkg holds:
//  - ANGLE_W=16
//  - atan table, 14 entries: 2000,12E4,09FB,0511,028B,0145,00A2,0051,0028,0014,000A,0005,0002,0001
//  - K_COMP=155
//  - state encoding IDLE/ITER/DONE
//  Sub-module cordic_vec_step: combinational single micro-rotation (x,y,z,i -> x',y',z').
//  Top level holds the FSM, counter, pre-rotation and output scaling.
// TESTING
//  Angle tolerance is +-0x0060 and magnitude tolerance is +-2 for STG=8.
//  (100,0) -> angle 0x0000, mag 100; done exactly 8 cycles after start edge.
//  (0,100) -> 0x4000/100; (-100,0) -> 0x8000/100; (0,-100) -> 0xC000/100.
//  (70,70) -> 0x2000, mag 99; (-128,-128) -> 0xA000, mag 181.
//  start held high throughout an operation -> second op begins only after DONE.
//  - New x_in/y_in values applied mid-ITER have no effect on the result.
//  RST_N low mid-ITER -> busy=0, done=0, outputs 0 at the next edge; no done pulse follows.
//  Sweep x_in,y_in over -128..127 step 8 vs real-valued atan2/hypot model -> all within tolerance.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, arctangent table and FSM encoding for the vectoring CORDIC
package cordic_pkg;

   localparam int             ANGLE_W = 16;
   localparam logic [8:0]     K_COMP  = 9'd155;
   localparam logic [15:0]    Z_PI2   = 16'h4000;
   localparam logic [15:0]    Z_NPI2  = 16'hC000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   // atan(2^-i) in binary-angle units (0x8000 = pi)
   function automatic logic [ANGLE_W-1:0] atan_lut(input logic [3:0] i);
      case (i)
         4'd0:    atan_lut = 16'h2000;
         4'd1:    atan_lut = 16'h12E4;
         4'd2:    atan_lut = 16'h09FB;
         4'd3:    atan_lut = 16'h0511;
         4'd4:    atan_lut = 16'h028B;
         4'd5:    atan_lut = 16'h0145;
         4'd6:    atan_lut = 16'h00A2;
         4'd7:    atan_lut = 16'h0051;
         4'd8:    atan_lut = 16'h0028;
         4'd9:    atan_lut = 16'h0014;
         4'd10:   atan_lut = 16'h000A;
         4'd11:   atan_lut = 16'h0005;
         4'd12:   atan_lut = 16'h0002;
         4'd13:   atan_lut = 16'h0001;
         default: atan_lut = 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// rtl/cordic_vec_step.sv - one combinational vectoring micro-rotation driving y toward zero
module cordic_vec_step
   import cordic_pkg::*;
#(
   parameter int W = 10
) (
   input  logic signed [W-1:0]       x,
   input  logic signed [W-1:0]       y,
   input  logic        [ANGLE_W-1:0] z,
   input  logic        [3:0]         i,
   output logic signed [W-1:0]       x_next,
   output logic signed [W-1:0]       y_next,
   output logic        [ANGLE_W-1:0] z_next
);

   logic signed [W-1:0]  x_sh;
   logic signed [W-1:0]  y_sh;
   logic [ANGLE_W-1:0]   a;

   always_comb begin
      x_sh = x >>> i;
      y_sh = y >>> i;
      a    = atan_lut(i);
      if (!y[W-1]) begin
         x_next = x + y_sh;
         y_next = y - x_sh;
         z_next = z + a;
      end else begin
         x_next = x - y_sh;
         y_next = y + x_sh;
         z_next = z - a;
      end
   end

endmodule

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring CORDIC returning phase and gain-compensated magnitude
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int XY_SZ = 8,
   parameter int STG   = 8
) (
   input  logic                    CLK_100MHZ,
   input  logic                    RST_N,
   input  logic                    start,
   input  logic signed [XY_SZ-1:0] x_in,
   input  logic signed [XY_SZ-1:0] y_in,
   output logic                    busy,
   output logic                    done,
   output logic [ANGLE_W-1:0]      angle_out,
   output logic [XY_SZ:0]          mag_out
);

   localparam int                 W       = XY_SZ + 2;
   localparam logic [3:0]         LAST    = 4'(STG - 1);
   localparam logic signed [W+8:0] MAG_MAX = (W+9)'((1 << (XY_SZ + 1)) - 1);

   state_t                state;
   logic [3:0]            cnt;
   logic                  zero_in;
   logic signed [W-1:0]   x, y, x_n, y_n, xe, ye, x0, y0;
   logic [ANGLE_W-1:0]    z, z_n, z0;
   logic signed [W+8:0]   prod, scaled;
   logic [XY_SZ:0]        mag_c;

   assign xe = {{2{x_in[XY_SZ-1]}}, x_in};
   assign ye = {{2{y_in[XY_SZ-1]}}, y_in};

   // Fold the left half-plane into |angle| <= pi/2 so the micro-rotations converge
   always_comb begin
      x0 = xe;
      y0 = ye;
      z0 = '0;
      if (xe[W-1]) begin
         if (!ye[W-1]) begin
            x0 = ye;
            y0 = -xe;
            z0 = Z_PI2;
         end else begin
            x0 = -ye;
            y0 = xe;
            z0 = Z_NPI2;
         end
      end
   end

   cordic_vec_step #(.W(W)) u_step (
      .x      (x),
      .y      (y),
      .z      (z),
      .i      (cnt),
      .x_next (x_n),
      .y_next (y_n),
      .z_next (z_n)
   );

   assign prod   = (W+9)'(x_n) * (W+9)'($signed(K_COMP));
   assign scaled = prod >>> 8;

   always_comb begin
      mag_c = scaled[XY_SZ:0];
      if (scaled < 0)
         mag_c = '0;
      else if (scaled > MAG_MAX)
         mag_c = '1;
   end

   always_ff @(posedge CLK_100MHZ) begin
      if (!RST_N) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         angle_out <= '0;
         mag_out   <= '0;
         zero_in   <= 1'b0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x       <= x0;
                  y       <= y0;
                  z       <= z0;
                  zero_in <= (x_in == '0) && (y_in == '0);
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= ITER;
               end
            end
            ITER: begin
               x   <= x_n;
               y   <= y_n;
               z   <= z_n;
               cnt <= cnt + 4'd1;
               if (cnt == LAST) begin
                  // A zero vector has no phase; report 0 rather than the summed table
                  angle_out <= zero_in ? '0 : z_n;
                  mag_out   <= mag_c;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
